// File: rtl/fp_ctrl_pkg.sv
// rtl/fp_ctrl_pkg.sv - shared encodings for the FP control slice
package fp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_WRITE   = 3'd5,
        ST_LOAD_WB = 3'd6,
        ST_ERR     = 3'd7
    } fp_state_t;

    localparam logic [1:0] OP_FADD = 2'b00;
    localparam logic [1:0] OP_FSUB = 2'b01;
    localparam logic [1:0] OP_FMUL = 2'b10;
    localparam logic [1:0] OP_FLW  = 2'b11;

    localparam logic [2:0] RM_RNE  = 3'b000;
    localparam logic [2:0] RM_RTZ  = 3'b001;
    localparam logic [2:0] RM_RDN  = 3'b010;
    localparam logic [2:0] RM_RUP  = 3'b011;
    localparam logic [2:0] RM_RMM  = 3'b100;
    localparam logic [2:0] RM_ILL5 = 3'b101;
    localparam logic [2:0] RM_ILL6 = 3'b110;
    localparam logic [2:0] RM_DYN  = 3'b111;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_RM      = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Instruction field wins unless it asks for the dynamic mode from fcsr.
    function automatic logic [2:0] resolve_rm(input logic [2:0] rm_insn, input logic [2:0] frm);
        return (rm_insn == RM_DYN) ? frm : rm_insn;
    endfunction

    function automatic logic rm_illegal(input logic [2:0] rm);
        return (rm == RM_ILL5) || (rm == RM_ILL6);
    endfunction

endpackage

// File: rtl/fp_timeout_counter.sv
// rtl/fp_timeout_counter.sv - 8-bit wait counter flagging the last allowed WAIT cycle
module fp_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic hit
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign hit = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/fp_sequencer.sv
// rtl/fp_sequencer.sv - FP-side control sequencer: operand read, ALU handshake, result write-back
module fp_sequencer
    import fp_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [1:0] op,
    input  logic [2:0] rm_insn,
    input  logic [2:0] frm,
    input  logic       done_fp,
    output logic       busy,
    output logic       ack,
    output logic [1:0] err,
    output logic       load_rs1_fp,
    output logic       load_rs2_fp,
    output logic       start_add_sub_fp,
    output logic       start_mult_fp,
    output logic       sub_fp,
    output logic [2:0] rounding_mode,
    output logic       load_alu_fp,
    output logic       load_fp_regfile,
    output logic       sel_rd_fp
);

    fp_state_t  state;
    logic [1:0] op_q;
    logic       to_hit;
    logic [2:0] rm_res;

    assign rm_res = resolve_rm(rm_insn, frm);

    fp_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clear (state == ST_START),
        .en    ((state == ST_WAIT) && !done_fp),
        .hit   (to_hit)
    );

    // Outputs are registered alongside the state they belong to, so each
    // branch sets the strobes of the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            op_q             <= OP_FADD;
            busy             <= 1'b0;
            ack              <= 1'b0;
            err              <= ERR_OK;
            load_rs1_fp      <= 1'b0;
            load_rs2_fp      <= 1'b0;
            start_add_sub_fp <= 1'b0;
            start_mult_fp    <= 1'b0;
            sub_fp           <= 1'b0;
            rounding_mode    <= RM_RNE;
            load_alu_fp      <= 1'b0;
            load_fp_regfile  <= 1'b0;
            sel_rd_fp        <= 1'b0;
        end else begin
            ack              <= 1'b0;
            err              <= ERR_OK;
            load_rs1_fp      <= 1'b0;
            load_rs2_fp      <= 1'b0;
            start_add_sub_fp <= 1'b0;
            start_mult_fp    <= 1'b0;
            load_alu_fp      <= 1'b0;
            load_fp_regfile  <= 1'b0;
            sel_rd_fp        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        op_q          <= op;
                        sub_fp        <= (op == OP_FSUB);
                        rounding_mode <= rm_res;
                        busy          <= 1'b1;
                        if (op == OP_FLW) begin
                            state           <= ST_LOAD_WB;
                            load_fp_regfile <= 1'b1;
                            sel_rd_fp       <= 1'b1;
                            ack             <= 1'b1;
                        end else if (rm_illegal(rm_res)) begin
                            state <= ST_ERR;
                            ack   <= 1'b1;
                            err   <= ERR_RM;
                        end else begin
                            state       <= ST_READ;
                            load_rs1_fp <= 1'b1;
                            load_rs2_fp <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    state            <= ST_START;
                    start_add_sub_fp <= (op_q != OP_FMUL);
                    start_mult_fp    <= (op_q == OP_FMUL);
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion arriving on the limit cycle still wins.
                    if (done_fp) begin
                        state       <= ST_CAPTURE;
                        load_alu_fp <= 1'b1;
                    end else if (to_hit) begin
                        state <= ST_ERR;
                        ack   <= 1'b1;
                        err   <= ERR_TIMEOUT;
                    end
                end
                ST_CAPTURE: begin
                    state           <= ST_WRITE;
                    load_fp_regfile <= 1'b1;
                    ack             <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sequencer.sv
// tb/tb_fp_sequencer.sv - self-checking bench for fp_sequencer with a cycle-schedule model
module tb_fp_sequencer;

    localparam int TO = 8;
    localparam int NCYC = 1024;

    typedef struct packed {
        logic       busy;
        logic       ack;
        logic [1:0] err;
        logic       ld1;
        logic       ld2;
        logic       sadd;
        logic       smul;
        logic       sub;
        logic [2:0] rm;
        logic       ldalu;
        logic       ldrf;
        logic       sel;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic [1:0] op = 2'b00;
    logic [2:0] rm_insn = 3'b000;
    logic [2:0] frm = 3'b000;
    logic       done_fp = 1'b0;
    logic       busy, ack, load_rs1_fp, load_rs2_fp, start_add_sub_fp, start_mult_fp;
    logic       sub_fp, load_alu_fp, load_fp_regfile, sel_rd_fp;
    logic [1:0] err;
    logic [2:0] rounding_mode;

    fp_sequencer #(.TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .op               (op),
        .rm_insn          (rm_insn),
        .frm              (frm),
        .done_fp          (done_fp),
        .busy             (busy),
        .ack              (ack),
        .err              (err),
        .load_rs1_fp      (load_rs1_fp),
        .load_rs2_fp      (load_rs2_fp),
        .start_add_sub_fp (start_add_sub_fp),
        .start_mult_fp    (start_mult_fp),
        .sub_fp           (sub_fp),
        .rounding_mode    (rounding_mode),
        .load_alu_fp      (load_alu_fp),
        .load_fp_regfile  (load_fp_regfile),
        .sel_rd_fp        (sel_rd_fp)
    );

    always #5 clk = ~clk;

    outs_t cur_o;
    assign cur_o = {busy, ack, err, load_rs1_fp, load_rs2_fp, start_add_sub_fp, start_mult_fp,
                    sub_fp, rounding_mode, load_alu_fp, load_fp_regfile, sel_rd_fp};

    outs_t exp_o   [0:NCYC-1];
    bit    chk_rm  [0:NCYC-1];
    outs_t act_log [0:NCYC-1];
    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Every cycle, outputs 1 after the edge are compared with the schedule.
    initial begin
        outs_t m;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            act_log[cyc] = cur_o;
            m = '1;
            if (!chk_rm[cyc]) begin
                m.sub = 1'b0;
                m.rm  = 3'b000;
            end
            n_tests++;
            if ((cur_o & m) !== (exp_o[cyc] & m)) begin
                n_fail++;
                $display("FAIL cycle %0d outputs: got %h, expected %h", cyc, cur_o & m, exp_o[cyc] & m);
            end
        end
    end

    // Builds the expected output timeline of one operation accepted at cycle a.
    task automatic model_txn(input int a, input logic [1:0] o, input logic [2:0] ri, input logic [2:0] f,
                             input int delay, output int e);
        logic [2:0] rm;
        bit ok;
        rm = (ri == 3'b111) ? f : ri;
        if (o == 2'b11) begin
            e = a + 1;
            exp_o[e].ldrf = 1'b1;
            exp_o[e].sel  = 1'b1;
        end else if (rm == 3'b101 || rm == 3'b110) begin
            e = a + 1;
            exp_o[e].err = 2'b01;
        end else begin
            ok = (delay >= 1) && (delay <= TO);
            exp_o[a+1].ld1 = 1'b1;
            exp_o[a+1].ld2 = 1'b1;
            if (o == 2'b10) exp_o[a+2].smul = 1'b1;
            else exp_o[a+2].sadd = 1'b1;
            if (ok) begin
                e = a + 4 + delay;
                exp_o[a+3+delay].ldalu = 1'b1;
                exp_o[e].ldrf = 1'b1;
            end else begin
                e = a + 3 + TO;
                exp_o[e].err = 2'b10;
            end
            for (int c = a + 1; c <= (ok ? e : e - 1); c++) begin
                exp_o[c].sub = (o == 2'b01);
                exp_o[c].rm  = rm;
                chk_rm[c] = 1'b1;
            end
        end
        for (int c = a + 1; c <= e; c++) exp_o[c].busy = 1'b1;
        exp_o[e].ack = 1'b1;
    endtask

    // Called just after a falling edge; returns after the falling edge following ack.
    task automatic txn(input logic [1:0] o, input logic [2:0] ri, input logic [2:0] f, input int delay,
                       input bit stray, input bit b2b, output int a, output int e);
        int dc;
        a = cyc;
        req = 1'b1;
        op = o;
        rm_insn = ri;
        frm = f;
        model_txn(a, o, ri, f, delay, e);
        dc = (delay > 0) ? a + 2 + delay : -1;
        while (cyc < e) begin
            @(negedge clk);
            op = 2'($urandom);
            rm_insn = 3'($urandom);
            done_fp = (cyc == dc) || (stray && cyc == a + 1);
        end
        done_fp = 1'b0;
        if (!b2b) req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int a, e, a2, e2, s;
        for (int c = 0; c < NCYC; c++) begin
            exp_o[c] = '0;
            chk_rm[c] = 1'b0;
        end
        @(posedge clk);
        #2;
        chk("reset_outputs", int'(cur_o), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // FADD, done four cycles after start
        txn(2'b00, 3'b000, 3'b011, 4, 1'b0, 1'b0, a, e);
        chk("fadd_read", act_log[a+1].ld1, 1);
        chk("fadd_start", act_log[a+2].sadd, 1);
        chk("fadd_capture", act_log[a+7].ldalu, 1);
        chk("fadd_ack", {act_log[a+8].ack, act_log[a+8].ldrf, act_log[a+8].err}, 4'b1100);
        chk("fadd_rm", act_log[a+8].rm, 0);

        // FSUB with dynamic rounding mode and a stray done in READ
        txn(2'b01, 3'b111, 3'b010, 1, 1'b1, 1'b0, a, e);
        s = 0;
        for (int c = a; c <= e; c++) s += int'(act_log[c].sadd) + int'(act_log[c].smul);
        chk("fsub_one_start", s, 1);
        chk("fsub_sub_rm", {act_log[a+1].sub, act_log[a+1].rm}, 4'b1010);
        chk("fsub_ack_cycle", e - a, 5);

        // FMUL with illegal static mode
        txn(2'b10, 3'b101, 3'b000, 3, 1'b0, 1'b0, a, e);
        chk("ill_ack", {act_log[a+1].ack, act_log[a+1].err, act_log[a+1].ldrf}, 4'b1010);

        // FLW back-to-back, second one with an otherwise illegal mode
        txn(2'b11, 3'b000, 3'b000, 0, 1'b0, 1'b1, a, e);
        txn(2'b11, 3'b110, 3'b000, 0, 1'b0, 1'b0, a2, e2);
        chk("flw_ack", {act_log[a+1].ack, act_log[a+1].ldrf, act_log[a+1].sel}, 3'b111);
        chk("flw_b2b_ack", {act_log[a+3].ack, act_log[a+3].sel, act_log[a+3].err}, 4'b1100);

        // FMUL with dynamic illegal mode
        txn(2'b10, 3'b111, 3'b110, 2, 1'b0, 1'b0, a, e);

        // FMUL timeout
        txn(2'b10, 3'b001, 3'b000, 0, 1'b0, 1'b0, a, e);
        chk("to_ack", {act_log[a+3+TO].ack, act_log[a+3+TO].err, act_log[a+3+TO].ldrf}, 4'b1100);
        chk("to_busy_drop", act_log[a+4+TO].busy, 0);

        // done on the last allowed WAIT cycle still completes
        txn(2'b10, 3'b100, 3'b000, TO, 1'b0, 1'b0, a, e);
        chk("limit_done_ack", {act_log[a+4+TO].ack, act_log[a+4+TO].err}, 3'b100);

        // reset in the middle of WAIT
        a = cyc;
        req = 1'b1;
        op = 2'b10;
        rm_insn = 3'b000;
        model_txn(a, 2'b10, 3'b000, 3'b000, 0, e);
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        req = 1'b0;
        for (int c = cyc + 1; c < NCYC; c++) begin
            exp_o[c] = '0;
            chk_rm[c] = 1'b0;
        end
        #1;
        chk("mid_reset_outputs", int'(cur_o), 0);
        @(negedge clk);
        reset = 1'b0;
        done_fp = 1'b1;
        @(negedge clk);
        done_fp = 1'b0;
        repeat (2) @(negedge clk);

        // fresh operation after reset
        txn(2'b00, 3'b011, 3'b000, 1, 1'b0, 1'b0, a, e);
        chk("fresh_ack", {act_log[a+5].ack, act_log[a+5].ldrf}, 2'b11);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_sequencer.md
# fp_sequencer

Multicycle sequencer for the floating-point slice of the RV64F dataflow: FP register-file read latches, FP ALU start/done handshake, result latch and FP register-file write. The main control FSM hands it one FP operation with a req/ack handshake, then stalls until ack. It owns all FP-side control strobes, so the integer control path never touches FP timing.

## Interface
Parameters:
- TIMEOUT, 64: maximum cycles waited in WAIT for done_fp before aborting; legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  operation request from main control; level, held until ack.
- op  in  2  00 FADD.S, 01 FSUB.S, 10 FMUL.S, 11 FLW write-back.
- rm_insn  in  3  rounding-mode field of the instruction (funct3).
- frm  in  3  dynamic rounding mode from fcsr.
- done_fp  in  1  FP ALU completion.
- busy  out  1  high from acceptance through the ack cycle.
- ack  out  1  one-cycle completion pulse.
- err  out  2  valid with ack: 00 ok, 01 illegal rounding mode, 10 timeout.
- load_rs1_fp, load_rs2_fp  out  1 each  FP operand register loads.
- start_add_sub_fp, start_mult_fp  out  1 each  one-cycle FP ALU start pulses.
- sub_fp  out  1  subtract select.
- rounding_mode  out  3  resolved rounding mode.
- load_alu_fp  out  1  FP result register load.
- load_fp_regfile  out  1  FP register-file write enable.
- sel_rd_fp  out  1  0 selects the ALU result, 1 selects the memory value.

## Operation
- States: IDLE, READ, START, WAIT, CAPTURE, WRITE, LOAD_WB, ERR.
- IDLE: when req=1, latch op, sub_fp=(op==01) and the resolved rounding mode.
  - Resolved mode is frm if rm_insn==111, else rm_insn.
  - Resolved value 101 or 110 is illegal: go to ERR with err=01.
  - op==11 goes to LOAD_WB; otherwise go to READ. The rounding-mode check does not apply to op==11.
- READ: load_rs1_fp=load_rs2_fp=1 for one cycle, then START.
- START: one-cycle start_add_sub_fp (op 00/01) or start_mult_fp (op 10), then WAIT. The timeout counter clears in this cycle.
- WAIT: done_fp is sampled only in this state.
  - done_fp=1 goes to CAPTURE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no done_fp, go to ERR with err=10.
- CAPTURE: load_alu_fp=1, then WRITE.
- WRITE: load_fp_regfile=1, sel_rd_fp=0, ack=1, err=00, then IDLE.
- LOAD_WB: load_fp_regfile=1, sel_rd_fp=1, ack=1, err=00, then IDLE.
- ERR: ack=1 with the latched err, no register-file write, then IDLE.
- Output hold rules:
  - sub_fp and rounding_mode hold their latched values from READ through WRITE.
  - All other strobes are 0 outside the states that name them.
  - busy=1 in every state except IDLE.

## Timing
- Reset (asynchronous): state IDLE, counter 0, every output 0 including rounding_mode and err. A reset mid-operation drops the operation with no ack and no write.
- Arithmetic latency: accept at cycle 0; READ 1; START 2; done_fp first seen at cycle d≥3; CAPTURE d+1; WRITE/ack d+2.
- FLW: accept at cycle 0, LOAD_WB/ack at cycle 1.
- Illegal rounding mode: accept at cycle 0, ERR/ack at cycle 1.
- Timeout: ack with err=10 exactly TIMEOUT cycles after the first WAIT cycle.
- Back-to-back requests: if req is still high in the cycle after ack, it is accepted as a new request. The requester must drop req on ack to avoid re-issue.
- done_fp asserted outside WAIT is ignored. done_fp in the same cycle the counter hits the limit wins: go to CAPTURE.
- op and rm_insn are don't-care after the acceptance cycle.

## Structure
- Shared package fp_ctrl_pkg holds:
  - state encoding (3-bit),
  - op codes OP_FADD/OP_FSUB/OP_FMUL/OP_FLW,
  - rounding-mode constants RM_RNE..RM_DYN and the illegal values,
  - err codes.
- One sub-module, fp_timeout_counter: 8-bit counter with clear and enable inputs and a hit output that compares against TIMEOUT-1.
- Everything else is a single FSM with registered state and Moore outputs.

## Test plan
- FADD, rm_insn=000, done_fp raised 4 cycles after start -> READ at 1, start_add_sub_fp at 2, load_alu_fp at 7, load_fp_regfile+ack at 8; sub_fp=0, rounding_mode=000, err=00.
- FSUB with rm_insn=111, frm=010 -> sub_fp=1 and rounding_mode=010 held from READ through WRITE; exactly one start pulse.
- FMUL with rm_insn=101 -> ack at cycle 1, err=01, no start pulse, load_fp_regfile never asserted.
- FLW (op=11) -> load_fp_regfile=1, sel_rd_fp=1, ack at cycle 1; back-to-back req accepted at cycle 2.
- TIMEOUT=8, FMUL with done_fp never raised -> ack with err=10 eight cycles after first WAIT cycle; no regfile write; busy drops the following cycle.
- reset asserted during WAIT -> all outputs 0 immediately; a stale done_fp in the next cycle causes no write; a fresh req starts cleanly.
